parking_slot_manager: RTL and testbench

Parametrised successor to the three-car enter/exit tracker. Manages NUM_SLOTS parking slots, each with its own elapsed-time counter driven by a shared time-unit tick. Computes a fee on exit: base fee plus per-tick rate, saturated. Reports occupancy, full status and protocol errors. Sits between the gate/keypad input logic and the cost display / seven-segment driver.

---
 rtl/parking_slot_manager_if.sv | 27 ++
 rtl/parking_slot_manager.sv | 136 +++++++++++++
 tb/tb_parking_slot_manager.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_slot_manager_if.sv
// rtl/parking_slot_manager_if.sv - request/status bundle between gate logic and the slot manager
interface parking_slot_manager_if #(
    parameter int NUM_SLOTS = 4,
    parameter int COST_W    = 12
);
    logic                             tick;
    logic                             enter_req;
    logic                             exit_req;
    logic [NUM_SLOTS-1:0]             slot_sel;
    logic [NUM_SLOTS-1:0]             slot_state;
    logic [$clog2(NUM_SLOTS+1)-1:0]   occupied_count;
    logic                             full;
    logic [COST_W-1:0]                last_cost;
    logic                             cost_valid;
    logic                             err;
    logic [1:0]                       err_code;

    modport master (
        output tick, enter_req, exit_req, slot_sel,
        input  slot_state, occupied_count, full, last_cost, cost_valid, err, err_code
    );

    modport slave (
        input  tick, enter_req, exit_req, slot_sel,
        output slot_state, occupied_count, full, last_cost, cost_valid, err, err_code
    );
endinterface

// File: rtl/parking_slot_manager.sv
// rtl/parking_slot_manager.sv - per-slot occupancy, elapsed-time counters and exit fee computation
module parking_slot_manager #(
    parameter int NUM_SLOTS = 4,
    parameter int TIME_W    = 10,
    parameter int COST_W    = 12,
    parameter int RATE      = 1,
    parameter int BASE_FEE  = 0
) (
    input logic clk,
    input logic reset,
    parking_slot_manager_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    // Wide enough that BASE_FEE + elapsed*RATE can never overflow before saturation.
    localparam int FEE_W = TIME_W + 34;
    localparam logic [FEE_W-1:0] COST_MAX = (FEE_W'(1) << COST_W) - FEE_W'(1);
    localparam logic [0:0] FREE     = 1'b0;
    localparam logic [0:0] OCCUPIED = 1'b1;

    logic [NUM_SLOTS-1:0] slot_state_q;
    logic [TIME_W-1:0]    elapsed_q [NUM_SLOTS];
    logic [CNT_W-1:0]     count_q;
    logic                 full_q;
    logic [COST_W-1:0]    last_cost_q;
    logic                 cost_valid_q;
    logic                 err_q;
    logic [1:0]           err_code_q;

    logic                 one_hot;
    logic                 sel_busy;
    logic                 reject;
    logic [1:0]           reject_code;
    logic                 acc_enter;
    logic                 acc_exit;
    logic [TIME_W-1:0]    sel_elapsed;
    logic [FEE_W-1:0]     fee_full;
    logic [COST_W-1:0]    fee_sat;
    logic [NUM_SLOTS-1:0] state_next;
    logic [CNT_W-1:0]     count_next;

    // Validate the request in priority order; any rejection blocks all slot updates.
    always_comb begin
        one_hot     = (bus.slot_sel != '0) &&
                      ((bus.slot_sel & (bus.slot_sel - NUM_SLOTS'(1))) == '0);
        sel_busy    = |(bus.slot_sel & slot_state_q);
        reject      = 1'b0;
        reject_code = 2'd0;
        if (bus.enter_req && bus.exit_req) begin
            reject      = 1'b1;
            reject_code = 2'd3;
        end else if ((bus.enter_req || bus.exit_req) && !one_hot) begin
            reject      = 1'b1;
            reject_code = 2'd0;
        end else if (bus.enter_req && sel_busy) begin
            reject      = 1'b1;
            reject_code = 2'd1;
        end else if (bus.exit_req && !sel_busy) begin
            reject      = 1'b1;
            reject_code = 2'd2;
        end
        acc_enter = bus.enter_req && !reject;
        acc_exit  = bus.exit_req && !reject;
    end

    // Fee from the selected slot's pre-edge count, saturated to the output width.
    always_comb begin
        sel_elapsed = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.slot_sel[i]) sel_elapsed = sel_elapsed | elapsed_q[i];
        end
        fee_full = FEE_W'(BASE_FEE) + FEE_W'(sel_elapsed) * FEE_W'(RATE);
        fee_sat  = (fee_full > COST_MAX) ? {COST_W{1'b1}} : fee_full[COST_W-1:0];
    end

    // Next occupancy and its population count, so count/full register alongside slot_state.
    always_comb begin
        state_next = slot_state_q;
        if (acc_enter) state_next = state_next | bus.slot_sel;
        if (acc_exit)  state_next = state_next & ~bus.slot_sel;
        count_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_next = count_next + CNT_W'(state_next[i]);
        end
    end

    // Slot FSMs and elapsed counters; a tick on the enter/exit edge of a slot is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_state_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) elapsed_q[i] <= '0;
        end else begin
            slot_state_q <= state_next;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (acc_enter && bus.slot_sel[i]) begin
                    elapsed_q[i] <= '0;
                end else if (acc_exit && bus.slot_sel[i]) begin
                    elapsed_q[i] <= elapsed_q[i];
                end else if (bus.tick && slot_state_q[i] == OCCUPIED &&
                             elapsed_q[i] != {TIME_W{1'b1}}) begin
                    elapsed_q[i] <= elapsed_q[i] + TIME_W'(1);
                end
            end
        end
    end

    // Status, fee and error registers; last_cost and err_code hold between events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            full_q       <= 1'b0;
            last_cost_q  <= '0;
            cost_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            count_q      <= count_next;
            full_q       <= (count_next == CNT_W'(NUM_SLOTS));
            cost_valid_q <= acc_exit;
            err_q        <= reject;
            if (acc_exit) last_cost_q <= fee_sat;
            if (reject)   err_code_q  <= reject_code;
        end
    end

    assign bus.slot_state     = slot_state_q;
    assign bus.occupied_count = count_q;
    assign bus.full           = full_q;
    assign bus.last_cost      = last_cost_q;
    assign bus.cost_valid     = cost_valid_q;
    assign bus.err            = err_q;
    assign bus.err_code       = err_code_q;

    // FREE names the cleared state bit; referenced here so both encodings stay documented.
    logic unused_free;
    assign unused_free = FREE[0];
endmodule

// File: tb/tb_parking_slot_manager.sv
// tb/tb_parking_slot_manager.sv - scoreboard bench for parking_slot_manager across three fee configurations
module tb_parking_slot_manager;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parking_slot_manager_if #(.NUM_SLOTS(4), .COST_W(12)) if_a ();
    parking_slot_manager_if #(.NUM_SLOTS(4), .COST_W(12)) if_b ();
    parking_slot_manager_if #(.NUM_SLOTS(4), .COST_W(10)) if_c ();

    parking_slot_manager #(.NUM_SLOTS(4), .TIME_W(10), .COST_W(12), .RATE(1), .BASE_FEE(0))
        u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    parking_slot_manager #(.NUM_SLOTS(4), .TIME_W(10), .COST_W(12), .RATE(3), .BASE_FEE(10))
        u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    parking_slot_manager #(.NUM_SLOTS(4), .TIME_W(10), .COST_W(10), .RATE(3), .BASE_FEE(10))
        u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    typedef struct {
        logic [3:0] state;
        int         count;
        logic       full;
        logic       err;
        logic [1:0] code;
        logic       cv;
        int         cost_a;
        int         cost_b;
        int         cost_c;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_el[4];
    logic [3:0] m_state;
    int         m_cost[3];
    logic [1:0] m_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fee(input int el, input int rate, input int base, input int max);
        int f;
        f = base + el * rate;
        return (f > max) ? max : f;
    endfunction

    task automatic drive(input logic en, input logic ex, input logic [3:0] sel, input logic tk);
        if_a.enter_req = en; if_a.exit_req = ex; if_a.slot_sel = sel; if_a.tick = tk;
        if_b.enter_req = en; if_b.exit_req = ex; if_b.slot_sel = sel; if_b.tick = tk;
        if_c.enter_req = en; if_c.exit_req = ex; if_c.slot_sel = sel; if_c.tick = tk;
    endtask

    task automatic compare_pending();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("slot_state", if_a.slot_state, e.state);
            check("occupied_count", if_a.occupied_count, e.count);
            check("full", if_a.full, e.full);
            check("err", if_a.err, e.err);
            check("err_code", if_a.err_code, e.code);
            check("cost_valid", if_a.cost_valid, e.cv);
            check("last_cost_a", if_a.last_cost, e.cost_a);
            check("last_cost_b", if_b.last_cost, e.cost_b);
            check("last_cost_c", if_c.last_cost, e.cost_c);
            check("cost_valid_c", if_c.cost_valid, e.cv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_el[i] = 0;
        m_state = 4'b0;
        for (int i = 0; i < 3; i++) m_cost[i] = 0;
        m_code = 2'd0;
    endtask

    task automatic step(input logic en, input logic ex, input logic [3:0] sel, input logic tk);
        exp_t       e;
        logic [3:0] dec;
        logic       oh;
        logic       busy;
        logic       acc_en;
        logic       acc_ex;
        @(negedge clk);
        compare_pending();
        drive(en, ex, sel, tk);
        dec  = sel - 4'd1;
        oh   = (sel != 4'd0) && ((sel & dec) == 4'd0);
        busy = |(sel & m_state);
        e.err = 1'b0;
        e.cv  = 1'b0;
        if (en && ex) begin
            e.err = 1'b1; m_code = 2'd3;
        end else if ((en || ex) && !oh) begin
            e.err = 1'b1; m_code = 2'd0;
        end else if (en && busy) begin
            e.err = 1'b1; m_code = 2'd1;
        end else if (ex && !busy) begin
            e.err = 1'b1; m_code = 2'd2;
        end
        acc_en = en && !e.err;
        acc_ex = ex && !e.err;
        for (int i = 0; i < 4; i++) begin
            if (acc_en && sel[i]) begin
                m_el[i] = 0;
            end else if (acc_ex && sel[i]) begin
                m_cost[0] = fee(m_el[i], 1, 0, 4095);
                m_cost[1] = fee(m_el[i], 3, 10, 4095);
                m_cost[2] = fee(m_el[i], 3, 10, 1023);
                e.cv = 1'b1;
            end else if (tk && m_state[i] && m_el[i] < 1023) begin
                m_el[i]++;
            end
        end
        if (acc_en) m_state = m_state | sel;
        if (acc_ex) m_state = m_state & ~sel;
        e.state  = m_state;
        e.count  = $countones(m_state);
        e.full   = (e.count == 4);
        e.code   = m_code;
        e.cost_a = m_cost[0];
        e.cost_b = m_cost[1];
        e.cost_c = m_cost[2];
        exp_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_slot_state"}, if_a.slot_state, 4'b0);
        check({tag, "_count"}, if_a.occupied_count, 0);
        check({tag, "_full"}, if_a.full, 1'b0);
        check({tag, "_last_cost"}, if_b.last_cost, 0);
        check({tag, "_cost_valid"}, if_a.cost_valid, 1'b0);
        check({tag, "_err"}, if_a.err, 1'b0);
        check({tag, "_err_code"}, if_a.err_code, 2'd0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        compare_pending();
        drive(1'b0, 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;
        #2;
        check_reset_state(tag);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 1'b0);
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;

        // Basic stay: 5 ticks on slot 0.
        step(1'b1, 1'b0, 4'b0001, 1'b0);
        ticks(5);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0);

        // 7 ticks on slot 2, then a saturating stay.
        step(1'b1, 1'b0, 4'b0100, 1'b0);
        ticks(7);
        step(1'b0, 1'b1, 4'b0100, 1'b0);
        step(1'b1, 1'b0, 4'b0100, 1'b0);
        ticks(1030);
        step(1'b0, 1'b1, 4'b0100, 1'b0);

        // Fill, overfill, free one.
        step(1'b1, 1'b0, 4'b0001, 1'b0);
        step(1'b1, 1'b0, 4'b0010, 1'b1);
        step(1'b1, 1'b0, 4'b0100, 1'b0);
        step(1'b1, 1'b0, 4'b1000, 1'b1);
        step(1'b1, 1'b0, 4'b0010, 1'b1);
        step(1'b0, 1'b1, 4'b1000, 1'b0);

        // Protocol errors and garbage select without a request.
        step(1'b1, 1'b0, 4'b0110, 1'b0);
        step(1'b1, 1'b1, 4'b0001, 1'b1);
        step(1'b0, 1'b1, 4'b1000, 1'b0);
        step(1'b0, 1'b0, 4'b1111, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b0010, 1'b0);
        step(1'b0, 1'b1, 4'b0100, 1'b0);

        // Ticks coinciding with enter and exit are not counted.
        step(1'b1, 1'b0, 4'b0001, 1'b1);
        ticks(2);
        step(1'b0, 1'b1, 4'b0001, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0);

        // Reset mid-stay discards occupancy; a later exit is rejected.
        step(1'b1, 1'b0, 4'b0001, 1'b0);
        ticks(2);
        step(1'b1, 1'b0, 4'b0010, 1'b1);
        ticks(2);
        apply_reset("mid");
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0);

        @(negedge clk);
        compare_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
